// File: rtl/binario_a_bcd_secuencial.sv
// Sequential binary to BCD converter (shift-and-add-3, one bit per clock).
// Optional clamp to 9999 with o_Desborde flag: define BCD_SATURACION_EN.
module binario_a_bcd_secuencial #(
    parameter int ANCHO = 14
) (
    input  logic             i_Reloj,
    input  logic             i_Reset,
    input  logic [ANCHO-1:0] i_Binario,
    input  logic             i_Inicio,
    output logic [3:0]       o_Datos_0,
    output logic [3:0]       o_Datos_1,
    output logic [3:0]       o_Datos_2,
    output logic [3:0]       o_Datos_3,
    output logic             o_Ocupado,
    output logic             o_Listo
`ifdef BCD_SATURACION_EN
    ,
    output logic             o_Desborde
`endif
);

    typedef enum logic [1:0] {
        REPOSO,
        CONVERSION,
        CARGA
    } estado_t;

    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMA = CW'(ANCHO - 1);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      datos_q, datos_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;
    logic [ANCHO-1:0] entrada;
    logic [14:0]      bcd_aj;

`ifdef BCD_SATURACION_EN
    localparam logic [15:0] MAX_BCD = 16'd9999;
    logic satura;
    logic satur_q, satur_d;
    logic desborde_q, desborde_d;

    // Clamp the incoming value to 9999 and remember that it was clamped
    always_comb begin
        satura  = {{(16-ANCHO){1'b0}}, i_Binario} > MAX_BCD;
        entrada = satura ? MAX_BCD[ANCHO-1:0] : i_Binario;
    end
`else
    // Without clamping the raw value is converted (result modulo 10000)
    always_comb begin
        entrada = i_Binario;
    end
`endif

    // Add 3 to every nibble >= 5; the top nibble's carry is dropped anyway
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bcd_aj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5)
                             ? bcd_q[4*i +: 4] + 4'd3
                             : bcd_q[4*i +: 4];
        end
        bcd_aj[14:12] = (bcd_q[15:12] >= 4'd5)
                      ? bcd_q[14:12] + 3'd3
                      : bcd_q[14:12];
    end

    // Next-state and datapath control for the three-state converter
    always_comb begin
        estado_d  = estado_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        datos_d   = datos_q;
        ocupado_d = ocupado_q;
        listo_d   = 1'b0;
`ifdef BCD_SATURACION_EN
        satur_d    = satur_q;
        desborde_d = desborde_q;
`endif
        unique case (estado_q)
            REPOSO: begin
                if (i_Inicio) begin
                    estado_d  = CONVERSION;
                    bin_d     = entrada;
                    bcd_d     = 16'h0000;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
`ifdef BCD_SATURACION_EN
                    satur_d = satura;
`endif
                end
            end
            CONVERSION: begin
                bcd_d = {bcd_aj, bin_q[ANCHO-1]};
                bin_d = {bin_q[ANCHO-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == ULTIMA) begin
                    estado_d = CARGA;
                end
            end
            CARGA: begin
                datos_d   = bcd_q;
                listo_d   = 1'b1;
                ocupado_d = 1'b0;
                estado_d  = REPOSO;
`ifdef BCD_SATURACION_EN
                desborde_d = satur_q;
`endif
            end
            default: begin
                estado_d  = REPOSO;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge i_Reloj) begin
        if (i_Reset) begin
            estado_q  <= REPOSO;
            bin_q     <= '0;
            bcd_q     <= 16'h0000;
            cnt_q     <= '0;
            datos_q   <= 16'h0000;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
`ifdef BCD_SATURACION_EN
            satur_q    <= 1'b0;
            desborde_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            datos_q   <= datos_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
`ifdef BCD_SATURACION_EN
            satur_q    <= satur_d;
            desborde_q <= desborde_d;
`endif
        end
    end

    assign o_Datos_0 = datos_q[3:0];
    assign o_Datos_1 = datos_q[7:4];
    assign o_Datos_2 = datos_q[11:8];
    assign o_Datos_3 = datos_q[15:12];
    assign o_Ocupado = ocupado_q;
    assign o_Listo   = listo_q;
`ifdef BCD_SATURACION_EN
    assign o_Desborde = desborde_q;
`endif

endmodule

// File: tb/tb_binario_a_bcd_secuencial.sv
// Scoreboard bench for binario_a_bcd_secuencial.
// Expected digits come from decimal arithmetic on the requested value.
module tb_binario_a_bcd_secuencial;

    localparam int ANCHO = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inicio = 1'b0;
    logic [ANCHO-1:0] bin = '0;
    logic [3:0]       d0, d1, d2, d3;
    logic             ocup, listo;
`ifdef BCD_SATURACION_EN
    logic             desb;
`endif

    binario_a_bcd_secuencial #(.ANCHO(ANCHO)) dut (
        .i_Reloj   (clk),
        .i_Reset   (rst),
        .i_Binario (bin),
        .i_Inicio  (inicio),
        .o_Datos_0 (d0),
        .o_Datos_1 (d1),
        .o_Datos_2 (d2),
        .o_Datos_3 (d3),
        .o_Ocupado (ocup),
        .o_Listo   (listo)
`ifdef BCD_SATURACION_EN
        ,
        .o_Desborde(desb)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [16:0] sb[$];
    int          pulses = 0;
    int          cyc = 0;
    logic        rst_edge = 1'b1;
    logic        prev_listo = 1'b0;
    logic [15:0] prev_datos = 16'h0;

    // Reference: plain decimal arithmetic; bit 16 is the expected overflow flag
    function automatic logic [16:0] modelo(int v);
        int   r;
        logic o;
        r = v;
        o = 1'b0;
        if (v > 9999) begin
`ifdef BCD_SATURACION_EN
            r = 9999;
            o = 1'b1;
`else
            r = v % 10000;
`endif
        end
        return {o, 4'(r / 1000), 4'((r / 100) % 10),
                4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero(string name);
        check({name, "_datos"}, int'({d3, d2, d1, d0}), 0);
        check({name, "_ocupado"}, int'(ocup), 0);
        check({name, "_listo"}, int'(listo), 0);
`ifdef BCD_SATURACION_EN
        check({name, "_desborde"}, int'(desb), 0);
`endif
    endtask

    // Waits for o_Listo, counting busy cycles seen along the way
    task automatic wait_listo(output int busy);
        bit seen;
        busy = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (listo) begin
                seen = 1;
                break;
            end
            if (ocup) busy++;
            tick();
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL listo_timeout: no o_Listo within 40 cycles");
        end
    endtask

    task automatic run(int v);
        int busy;
        bin = ANCHO'(v);
        inicio = 1'b1;
        sb.push_back(modelo(v));
        tick();
        inicio = 1'b0;
        wait_listo(busy);
        check("busy_cycles", busy, ANCHO + 1);
        tick();
    endtask

    always @(posedge clk) begin
        rst_edge <= rst;
        cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard on each o_Listo and checks output rules
    always @(negedge clk) begin
        logic [15:0] datos;
        logic [16:0] e;
        datos = {d3, d2, d1, d0};
        if (listo === 1'b1) begin
            pulses++;
            check("listo_width", int'(prev_listo), 0);
            check("ocupado_at_listo", int'(ocup), 0);
            check("digit_range",
                  int'(d0 <= 9 && d1 <= 9 && d2 <= 9 && d3 <= 9), 1);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_listo: digits %h", datos);
            end else begin
                e = sb.pop_front();
                check("digits", int'(datos), int'(e[15:0]));
`ifdef BCD_SATURACION_EN
                check("desborde", int'(desb), int'(e[16]));
`endif
            end
        end else if (datos !== prev_datos && !rst_edge) begin
            checks++;
            failures++;
            $display("FAIL datos_changed: got %h, held %h",
                     datos, prev_datos);
        end
        prev_listo = listo;
        prev_datos = datos;
    end

    initial begin
        int p0;
        int busy;
        int nl;
        int t_prev;

        // Reset with a coincident start request, which must be ignored
        rst = 1'b1;
        inicio = 1'b1;
        bin = ANCHO'(1234);
        idle(3);
        check_zero("reset");
        rst = 1'b0;
        inicio = 1'b0;
        tick();
        check("start_under_reset", int'(ocup), 0);
        idle(2);

        // Basic and boundary values
        run(1234);
        run(0);
        run(9999);
        run(16383);

        // Start request while busy is dropped
        p0 = pulses;
        bin = ANCHO'(42);
        inicio = 1'b1;
        sb.push_back(modelo(42));
        tick();
        inicio = 1'b0;
        idle(3);
        bin = ANCHO'(7777);
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        bin = ANCHO'(3333);
        wait_listo(busy);
        idle(25);
        check("busy_start_pulses", pulses - p0, 1);

        // Reset aborts a conversion: no pulse follows
        bin = ANCHO'(5678);
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        idle(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("abort");
        p0 = pulses;
        idle(25);
        check("abort_no_listo", pulses - p0, 0);
        run(901);

        // Start held high: pulses every ANCHO+2 cycles
        idle(2);
        bin = ANCHO'(310);
        inicio = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(modelo(310));
        nl = 0;
        t_prev = 0;
        for (int i = 0; i < 100 && nl < 4; i++) begin
            tick();
            if (listo) begin
                if (nl > 0) check("b2b_period", cyc - t_prev, ANCHO + 2);
                t_prev = cyc;
                nl++;
                if (nl == 4) inicio = 1'b0;
            end
        end
        check("b2b_count", nl, 4);
        inicio = 1'b0;
        idle(20);

        // Random values with random idle gaps
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(0, 3));
            run(int'($urandom_range(0, (1 << ANCHO) - 1)));
        end

        idle(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/binario_a_bcd_secuencial.md
BINARIO_A_BCD_SECUENCIAL -- requirements
Module: binario_a_bcd_secuencial

Interface
REQ-001 Parameter: ANCHO, default 14, input binary width; legal range 4..14.
REQ-002 Clock is i_Reloj; reset is synchronous and active-high, port i_Reset. Reset is sampled only on the rising edge of i_Reloj.
REQ-003 i_Reloj  input  1  system clock; all state changes on its rising edge.
REQ-004 i_Reset  input  1  synchronous, active-high reset.
REQ-005 i_Binario  input  ANCHO  unsigned value to convert; sampled only when a conversion starts.
REQ-006 i_Inicio  input  1  start request; acted on only in REPOSO.
REQ-007 o_Datos_0  output  4  BCD units digit.
REQ-008 o_Datos_1  output  4  BCD tens digit.
REQ-009 o_Datos_2  output  4  BCD hundreds digit.
REQ-010 o_Datos_3  output  4  BCD thousands digit.
REQ-011 o_Ocupado  output  1  high while a conversion is in progress.
REQ-012 o_Listo  output  1  one-cycle pulse when new digits are valid.
REQ-013 o_Desborde  output  1  present only with BCD_SATURACION_EN; high when the last result was clamped.

Function
REQ-014 FSM states: REPOSO, CONVERSION, CARGA.
- REPOSO -> CONVERSION on a rising edge where i_Inicio=1.
- CONVERSION -> CARGA after exactly ANCHO iterations.
- CARGA -> REPOSO unconditionally.
REQ-015 On the REPOSO->CONVERSION edge:
- latch i_Binario into the shift register;
- clear the 16-bit BCD scratch register;
- clear the iteration counter.
REQ-016 Each CONVERSION cycle performs one double-dabble iteration:
- add 3 to every scratch nibble whose value is 5 or more;
- then shift the {scratch, binary} register left by 1 bit.
REQ-017 Scratch bits shifted beyond bit 15 are discarded. Without the macro, outputs are the value modulo 10000.
REQ-018 Latency: i_Inicio sampled at edge k; iterations occur on edges k+1..k+ANCHO; the CARGA edge is k+ANCHO+1, which loads o_Datos_0..3 and sets o_Listo=1 for exactly one cycle.
REQ-019 o_Ocupado is 1 in CONVERSION and CARGA and 0 in REPOSO. It falls on the same edge that o_Listo rises.
REQ-020 o_Datos_0..3 hold the previous result throughout a conversion and never show intermediate values.
REQ-021 i_Inicio is ignored while o_Ocupado=1; there is no queuing.
REQ-022 i_Inicio held high continuously starts a new conversion on the first edge back in REPOSO. That is one idle cycle after the o_Listo pulse begins.
REQ-023 Changes on i_Binario after the start edge do not affect the conversion in progress.
REQ-024 Every output digit is always in the range 0..9.

Reset
REQ-025 i_Reset=1 at a rising edge forces the following, with priority over all other inputs:
- state REPOSO;
- o_Datos_0..3 = 4'h0;
- o_Ocupado = 0, o_Listo = 0, o_Desborde = 0;
- scratch register and iteration counter cleared.
REQ-026 Reset during CONVERSION or CARGA aborts the conversion; no o_Listo pulse follows.
REQ-027 i_Inicio=1 together with i_Reset=1 is ignored; it does not start a conversion after reset releases.

Configuration
REQ-028 Macro BCD_SATURACION_EN defined:
- at the start edge, if i_Binario > 9999 the converter loads 9999 instead;
- o_Desborde is registered with the CARGA load, then holds until the next CARGA or reset.
REQ-029 Macro BCD_SATURACION_EN undefined:
- o_Desborde port is absent;
- values above 9999 produce the value modulo 10000 (REQ-017).

Verification
REQ-030 Basic conversion, ANCHO=14: i_Binario=1234, i_Inicio pulse -> after 15 cycles o_Datos_3..0 = 1,2,3,4; o_Listo high for exactly 1 cycle; o_Ocupado high for exactly 15 cycles.
REQ-031 Boundary values: i_Binario=0 -> digits 0,0,0,0; then i_Binario=9999 -> 9,9,9,9; o_Desborde=0 in both cases.
REQ-032 Overflow: i_Binario=16383 -> with BCD_SATURACION_EN digits 9,9,9,9 and o_Desborde=1; without the macro digits 6,3,8,3.
REQ-033 Busy-start: start with 0042, pulse i_Inicio with 7777 at cycle 5 -> result 0,0,4,2; exactly one o_Listo pulse; the 7777 request is ignored.
REQ-034 Reset abort: start 5678, assert i_Reset at cycle 8 -> next cycle all outputs 0; no o_Listo pulse; a subsequent start with 0901 yields 0,9,0,1.
REQ-035 Back-to-back: i_Inicio held high with i_Binario=0310 -> o_Listo pulses repeat every 16 cycles; digits stay 0,3,1,0.
